matmul_operand_loader: RTL
==========================

Name: matmul_operand_loader

Overview:
- Upstream feeder for the 2x2 matrix-multiplier core.
- Accepts a byte stream with a valid/ready handshake and assembles the two OP_W-bit operand words a and b.
- Presents a and b to the core with a one-cycle ena start pulse, then enforces a quiet gap before accepting the next frame.
- Detects framing errors and resynchronises on the in_last marker.

Parameters:
- OP_W, 16, width of each operand word a/b; must be a multiple of 8 (BPO = OP_W/8 bytes per operand).
- GAP_CYCLES, 4, idle cycles after each ena pulse before the next byte is accepted; must be >= 1.
- CNT_W, 8, width of launch_count.

Ports:
- clk  input  1  the single clock; all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_data  input  8  operand byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  qualifies the final byte of a frame; meaningful only when in_valid=1.
- in_ready  output  1  loader accepts a byte this cycle; transfer happens when in_valid & in_ready.
- a  output  OP_W  operand A to the core; stable between launches.
- b  output  OP_W  operand B to the core; stable between launches.
- ena  output  1  one-cycle start pulse to the core.
- busy  output  1  high during LAUNCH and GAP.
- err  output  1  sticky framing-error flag.
- launch_count  output  CNT_W  number of successful launches; wraps modulo 2^CNT_W.

Behaviour:
- States: LOAD (collecting bytes), LAUNCH, GAP, RESYNC. A byte index idx runs 0..2*BPO-1.
- Reset (any cycle, including mid-frame):
  - state=LOAD, idx=0; shadow registers cleared.
  - a=0, b=0, ena=0, err=0, launch_count=0.
  - Partial frame discarded.
  - in_ready=1 from the first cycle after rst deasserts.
- in_ready is decoded from state only: 1 in LOAD and RESYNC, 0 in LAUNCH and GAP. It never depends on in_valid.
- LOAD: each accepted byte shifts MSB-first into shadow registers.
  - idx < BPO: byte goes to shadow A.
  - Otherwise: byte goes to shadow B.
  - idx increments on each accepted byte.
- Good frame: byte with idx=2*BPO-1 accepted together with in_last=1.
  - Next edge: a<=shadow A, b<=shadow B, ena=1, state=LAUNCH, idx=0, err cleared, launch_count+1.
  - Latency: ena and the new a/b appear in the same cycle, 1 cycle after the final handshake.
- Early last: in_last=1 accepted with idx < 2*BPO-1.
  - err<=1, idx<=0, stay in LOAD.
  - No ena; a/b unchanged. The next byte starts a fresh frame.
- Missing last: idx=2*BPO-1 accepted with in_last=0.
  - err<=1, state<=RESYNC.
  - No ena; a/b unchanged.
- RESYNC: accepted bytes are discarded. The first accepted byte with in_last=1 returns state to LOAD with idx=0; that byte is also discarded.
- LAUNCH: lasts exactly one cycle (ena=1, busy=1), then GAP.
- GAP: down-counter loaded with GAP_CYCLES; busy=1, ena=0.
  - Exits to LOAD when the counter reaches 0, after exactly GAP_CYCLES cycles.
  - Total in_ready=0 window per launch = 1+GAP_CYCLES cycles.
- in_valid while in_ready=0 is ignored. The source must hold its byte, which is accepted on the first in_ready=1 cycle.
- a and b change only at a launch or on reset; they are otherwise held indefinitely.
- launch_count wraps from 2^CNT_W-1 to 0 without side effects.
- err stays set until the next good launch or reset.

Test Plan:
- Good frame: bytes 12,34,56,78 on consecutive cycles, in_last on 78 -> one cycle later a=1234, b=5678, ena=1 for exactly 1 cycle, launch_count=1. Then busy=1 and in_ready=0 for 5 cycles, then in_ready=1.
- Back-to-back frames: frame FF,FF,00,01(last) with in_valid held high throughout the gap -> bytes are accepted only once in_ready returns, a=FFFF, b=0001, launch_count=2. No byte is lost or duplicated.
- Early last: 12, 34(last) -> err=1, no ena, a/b keep their previous values. Then AA,BB,CC,DD(last) -> a=AABB, b=CCDD, ena pulses, err=0.
- Missing last: 01,02,03,04 (no last), then 55, 66(last), then 11,22,33,44(last) -> err=1 after 04. 55 and 66 are discarded, no ena fires for them. Final frame gives a=1122, b=3344 and err clears.
- Reset mid-frame: 12,34 accepted, rst high 1 cycle, then 9A,BC,DE,F0(last) -> after reset a=0, b=0, err=0, launch_count=0. The fresh frame gives a=9ABC, b=DEF0.
- Wrap: force 255 good launches, then 1 more -> launch_count goes 255 to 0. ena still pulses once per frame.

Source files
------------

// File: rtl/matmul_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_operand_loader_if
// Description : Byte-stream input and operand/launch outputs of the 2x2
//               matrix-multiplier operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_operand_loader_if #(
    parameter int OP_W  = 16,
    parameter int CNT_W = 8
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             ena;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] launch_count;

    // Byte source and operand consumer side
    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, a, b, ena, busy, err, launch_count
    );

    // Loader side
    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, a, b, ena, busy, err, launch_count
    );
endinterface
`default_nettype wire

// File: rtl/matmul_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : matmul_operand_loader
// Description : Assembles operand words a/b from a framed byte stream, pulses
//               ena to the matmul core, then holds off input for a quiet gap.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_operand_loader #(
    parameter int OP_W       = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    matmul_operand_loader_if.slave  bus
);

    localparam int c_BPO   = OP_W / 8;
    localparam int c_IDX_W = (2 * c_BPO > 1) ? $clog2(2 * c_BPO) : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(2 * c_BPO - 1);
    localparam logic [c_IDX_W-1:0] c_B_START  = c_IDX_W'(c_BPO);
    // GAP lasts counter-value+1 cycles, so load one less than the gap length
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH = 2'd1;
    localparam logic [1:0] c_ST_GAP    = 2'd2;
    localparam logic [1:0] c_ST_RESYNC = 2'd3;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [OP_W-1:0]    r_sh_a;
    logic [OP_W-1:0]    r_sh_b;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic               r_err;
    logic [CNT_W-1:0]   r_launch_cnt;

    logic               w_ready;
    logic               w_xfer;
    logic [OP_W-1:0]    w_sh_a_next;
    logic [OP_W-1:0]    w_sh_b_next;

    assign w_ready = (r_state == c_ST_LOAD) || (r_state == c_ST_RESYNC);
    assign w_xfer  = bus.in_valid && w_ready;

    // MSB-first shift; a single-byte operand is simply replaced
    generate
        if (OP_W == 8) begin : g_shift_byte
            assign w_sh_a_next = bus.in_data;
            assign w_sh_b_next = bus.in_data;
        end else begin : g_shift_wide
            assign w_sh_a_next = {r_sh_a[OP_W-9:0], bus.in_data};
            assign w_sh_b_next = {r_sh_b[OP_W-9:0], bus.in_data};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_LOAD;
            r_idx        <= '0;
            r_gap_cnt    <= '0;
            r_sh_a       <= '0;
            r_sh_b       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_err        <= 1'b0;
            r_launch_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (w_xfer) begin
                        if (r_idx < c_B_START) begin
                            r_sh_a <= w_sh_a_next;
                        end else begin
                            r_sh_b <= w_sh_b_next;
                        end

                        if (r_idx == c_LAST_IDX) begin
                            r_idx <= '0;
                            if (bus.in_last) begin
                                // Final B byte is still in flight, take it from the shifter
                                r_a          <= r_sh_a;
                                r_b          <= w_sh_b_next;
                                r_err        <= 1'b0;
                                r_launch_cnt <= r_launch_cnt + 1'b1;
                                r_state      <= c_ST_LAUNCH;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= c_ST_RESYNC;
                            end
                        end else if (bus.in_last) begin
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                c_ST_LAUNCH: begin
                    r_gap_cnt <= c_GAP_LOAD;
                    r_state   <= c_ST_GAP;
                end

                c_ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= c_ST_LOAD;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end

                c_ST_RESYNC: begin
                    if (w_xfer && bus.in_last) begin
                        r_idx   <= '0;
                        r_state <= c_ST_LOAD;
                    end
                end

                default: begin
                    r_state <= c_ST_LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.ena          = (r_state == c_ST_LAUNCH);
    assign bus.busy         = (r_state == c_ST_LAUNCH) || (r_state == c_ST_GAP);
    assign bus.a            = r_a;
    assign bus.b            = r_b;
    assign bus.err          = r_err;
    assign bus.launch_count = r_launch_cnt;

endmodule
`default_nettype wire
